// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage : dmem_pkg

// File: rtl/dmem_ram_bank.sv
// Single-port synchronous word RAM with per-byte write enables and registered read data.
module dmem_ram_bank
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Store writes only the enabled bytes; a load refreshes the read register.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < int'(BE_W); b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][BYTE_W*b +: BYTE_W] <= wdata_i[BYTE_W*b +: BYTE_W];
                    end
                end
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule : dmem_ram_bank

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: handshake, wait states, RAM access, response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned AW          = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    localparam logic [32:0]      BYTE_LIMIT = 33'(DEPTH) * 33'd4;
    localparam logic [CNT_W-1:0] CNT_INIT   = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;

    logic              bad_req_c;
    logic              ram_en_c;
    logic [WORD_W-1:0] ram_rdata;

    // Misaligned or beyond the last word; no wrap-around.
    assign bad_req_c = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= BYTE_LIMIT);

    // State, capture and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Next-state logic; RESP first loads the response registers, then waits for the handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        err_d       = err_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        ram_en_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    waddr_d = req_addr[AW+1:2];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    err_d   = bad_req_c;
                    if (bad_req_c) begin
                        state_d = ST_RESP;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                ram_en_c = 1'b1;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = err_q;
                    rsp_rdata_d = (err_q || wr_q) ? '0 : ram_rdata;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    dmem_ram_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en_c),
        .we_i    (wr_q),
        .be_i    (be_q),
        .addr_i  (waddr_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b0;

    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        req_ready_a, req_ready_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;
    logic        rsp_error_a, rsp_error_b;

    logic        sel = 1'b0;
    logic        cur_req_ready, cur_rsp_valid, cur_rsp_error;
    logic [31:0] cur_rsp_rdata;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    assign cur_req_ready = sel ? req_ready_b : req_ready_a;
    assign cur_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    assign cur_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
    assign cur_rsp_error = sel ? rsp_error_b : rsp_error_a;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2), .AW(10)) u_dut_w2 (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
        .rsp_error(rsp_error_a)
    );

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0), .AW(10)) u_dut_w0 (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
        .rsp_error(rsp_error_b)
    );

    // Drive one request to the selected instance; returns #1 after the acceptance edge.
    task automatic send_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] exp_rd,
                            input logic exp_err, input int exp_lat);
        int   n = 0;
        exp_t e;
        while (cur_req_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (cur_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL req_ready_timeout addr=%h got=%b want=1", addr, cur_req_ready);
        end
        req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
        if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
    endtask

    // Wait for the response, compare to the scoreboard, hold it for 'hold' cycles, then consume.
    task automatic recv_rsp(input int hold);
        int          lat = 0;
        exp_t        e;
        logic [31:0] held;
        while (cur_rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty got=0 want=1 entry");
            return;
        end
        e = exp_q.pop_front();
        total++;
        if (cur_rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rsp_timeout got=%b want=1", cur_rsp_valid);
        end
        total++;
        if (lat !== e.lat) begin
            bad++;
            $display("FAIL latency got=%0d want=%0d", lat, e.lat);
        end
        total++;
        if (cur_rsp_rdata !== e.rdata) begin
            bad++;
            $display("FAIL rsp_rdata got=%h want=%h", cur_rsp_rdata, e.rdata);
        end
        total++;
        if (cur_rsp_error !== e.err) begin
            bad++;
            $display("FAIL rsp_error got=%b want=%b", cur_rsp_error, e.err);
        end
        held = cur_rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            total++;
            if (cur_rsp_valid !== 1'b1 || cur_rsp_rdata !== held || cur_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                         h, cur_rsp_valid, cur_rsp_rdata, cur_req_ready, held);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        total++;
        if (cur_rsp_valid !== 1'b0 || cur_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL handshake got v=%b rdy=%b want v=0 rdy=1", cur_rsp_valid, cur_req_ready);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        total++;
        if (req_ready_a !== 1'b1 || rsp_valid_a !== 1'b0 || rsp_rdata_a !== 32'h0 || rsp_error_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
                     req_ready_a, rsp_valid_a, rsp_rdata_a, rsp_error_a);
        end
        send_req(1'b1, 32'h10, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 4);
        recv_rsp(0);
        // Store that reset interrupts while waiting.
        send_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 4);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b1; #1;
        total++;
        if (req_ready_a !== 1'b1 || rsp_valid_a !== 1'b0 || rsp_rdata_a !== 32'h0 || rsp_error_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_wait got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
                     req_ready_a, rsp_valid_a, rsp_rdata_a, rsp_error_a);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send_req(1'b0, 32'h10, 32'h0, 4'hF, 32'h1111_1111, 1'b0, 4);
        recv_rsp(0);
    endtask

    task automatic test_latency();
        sel = 1'b0;
        send_req(1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 4);
        recv_rsp(0);
        send_req(1'b0, 32'h40, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 4);
        recv_rsp(0);
    endtask

    task automatic test_byte_enable();
        sel = 1'b0;
        send_req(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 4);
        recv_rsp(0);
        send_req(1'b0, 32'h40, 32'h0, 4'b0000, 32'h12BB_56DD, 1'b0, 4);
        recv_rsp(0);
        // Empty byte mask: legal store, nothing changes.
        send_req(1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 4);
        recv_rsp(0);
        send_req(1'b0, 32'h40, 32'h0, 4'b1010, 32'h12BB_56DD, 1'b0, 4);
        recv_rsp(0);
    endtask

    task automatic test_errors();
        sel = 1'b0;
        send_req(1'b0, 32'h41, 32'h0, 4'hF, 32'h0, 1'b1, 1);
        recv_rsp(0);
        send_req(1'b0, 32'd4096, 32'h0, 4'hF, 32'h0, 1'b1, 1);
        recv_rsp(0);
        send_req(1'b1, 32'h42, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 1);
        recv_rsp(0);
        send_req(1'b0, 32'h40, 32'h0, 4'hF, 32'h12BB_56DD, 1'b0, 4);
        recv_rsp(0);
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        send_req(1'b0, 32'h40, 32'h0, 4'hF, 32'h12BB_56DD, 1'b0, 4);
        // Competing store presented while busy must be ignored.
        req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h0; req_be = 4'hF;
        req_valid_a = 1'b1;
        recv_rsp(5);
        send_req(1'b0, 32'h40, 32'h0, 4'hF, 32'h12BB_56DD, 1'b0, 4);
        recv_rsp(0);
    endtask

    task automatic test_top_word_w0();
        sel = 1'b1;
        send_req(1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 2);
        recv_rsp(0);
        send_req(1'b0, 32'hFFC, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 2);
        recv_rsp(0);
        send_req(1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1, 1);
        recv_rsp(0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        send_req(1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 2);
        recv_rsp(0);
        send_req(1'b1, 32'h24, 32'h7654_3210, 4'b1100, 32'h0, 1'b0, 2);
        recv_rsp(0);
        send_req(1'b0, 32'h20, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, 2);
        recv_rsp(1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_latency();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_top_word_w0();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_responder
